// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register.
package pipe_pkg;

  localparam int PIPE_CTRL_W = 22;
  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  function automatic logic holds_entry(input pipe_state_e s);
    return (s != EMPTY);
  endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating back-pressure cycle counter; clear wins over increment.
module pipe_stall_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with bubble-zeroed control and stall counter.
// Define PIPE_STAGE_SKID_EN to add the skid entry (full throughput with registered in_ready).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              out_valid_q, out_valid_d;
  logic              in_fire;
  logic              out_fire;

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
`else
  assign in_ready = out_ready | ~out_valid_q;
`endif

  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;

  // Next-state and entry contents; m_ctrl is zeroed whenever M empties.
  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
`ifdef PIPE_STAGE_SKID_EN
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
`endif
    if (flush) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
`ifdef PIPE_STAGE_SKID_EN
      s_ctrl_d = '0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
            state_d  = ONE;
          end else begin
            state_d  = EMPTY;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
            state_d  = ONE;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_fire) begin
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
            state_d  = TWO;
`endif
          end else if (out_fire) begin
            m_ctrl_d = '0;
            state_d  = EMPTY;
          end else begin
            state_d  = ONE;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        TWO: begin
          if (out_fire) begin
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            state_d  = ONE;
          end else begin
            state_d  = TWO;
          end
        end
`endif
        default: begin
          m_ctrl_d = '0;
          state_d  = EMPTY;
        end
      endcase
    end
    out_valid_d = holds_entry(state_d);
`ifdef PIPE_STAGE_SKID_EN
    in_ready_d  = (state_d != TWO);
`endif
  end

  // Stage state and entry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      m_ctrl_q    <= '0;
      m_data_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      s_ctrl_q    <= '0;
      s_data_q    <= '0;
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      m_ctrl_q    <= m_ctrl_d;
      m_data_q    <= m_data_d;
      out_valid_q <= out_valid_d;
`ifdef PIPE_STAGE_SKID_EN
      s_ctrl_q    <= s_ctrl_d;
      s_data_q    <= s_data_d;
      in_ready_q  <= in_ready_d;
`endif
    end
  end

  pipe_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid_q & ~out_ready),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int CW = 22;
  localparam int DW = 128;
  localparam int NW = 16;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, flush, out_valid, out_ready, cnt_clr;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  item_t         q[$];
  logic [DW-1:0] last_data;
  int unsigned   cnt_m;

  pipe_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_data = '0;
    cnt_m     = 0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: drive, compare against the model, then advance the model at the edge.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic fl, input logic ordy, input logic clr);
    logic  exp_valid, exp_rdy, ifire, ofire;
    item_t it;
    @(negedge clk);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    exp_valid = (q.size() > 0);
`ifdef PIPE_STAGE_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = ordy || (q.size() == 0);
`endif
    check_eq("out_valid", DW'(out_valid), DW'(exp_valid));
    check_eq("in_ready", DW'(in_ready), DW'(exp_rdy));
    if (exp_valid) begin
      check_eq("out_ctrl", DW'(out_ctrl), DW'(q[0].c));
      check_eq("out_data", out_data, q[0].d);
    end else begin
      check_eq("out_ctrl_bubble", DW'(out_ctrl), '0);
      check_eq("out_data_hold", out_data, last_data);
    end
    check_eq("stall_cnt", DW'(stall_cnt), DW'(cnt_m));
    ifire = v && exp_rdy && !fl;
    ofire = exp_valid && ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) begin
        it.c = c;
        it.d = d;
        q.push_back(it);
      end
    end
    if (q.size() > 0) last_data = q[0].d;
    if (clr) cnt_m = 0;
    else if (exp_valid && !ordy && cnt_m < 32'd65535) cnt_m++;
  endtask

  initial begin : main
    item_t a, b, cc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", DW'(out_valid), '0);
    check_eq("rst_in_ready", DW'(in_ready), DW'(1'b1));
    check_eq("rst_out_ctrl", DW'(out_ctrl), '0);
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_stall_cnt", DW'(stall_cnt), '0);

    // Single-cycle latency with all-ones control.
    step(1'b1, 22'h3FFFFF, rnd_data(), 1'b0, 1'b1, 1'b0);
    #2;
    check_eq("lat_out_valid", DW'(out_valid), DW'(1'b1));
    check_eq("lat_out_ctrl", DW'(out_ctrl), DW'(22'h3FFFFF));
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: A then B, drained in order.
    a.c = CW'($urandom()); a.d = rnd_data();
    b.c = CW'($urandom()); b.d = rnd_data();
    step(1'b1, a.c, a.d, 1'b0, 1'b0, 1'b0);
    step(1'b1, b.c, b.d, 1'b0, 1'b0, 1'b0);
    #2;
`ifdef PIPE_STAGE_SKID_EN
    check_eq("bp_in_ready_full", DW'(in_ready), '0);
`endif
    check_eq("bp_first_A", DW'(out_ctrl), DW'(a.c));
    step(1'b1, b.c, b.d, 1'b0, 1'b1, 1'b0);
    #2;
    check_eq("bp_second_B", DW'(out_ctrl), DW'(b.c));
    check_eq("bp_second_B_data", out_data, b.d);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Flush while full with a same-cycle incoming entry.
    cc.c = CW'($urandom()) | CW'(1); cc.d = rnd_data();
    step(1'b1, a.c, a.d, 1'b0, 1'b0, 1'b0);
    step(1'b1, b.c, b.d, 1'b0, 1'b0, 1'b0);
    step(1'b1, cc.c, cc.d, 1'b1, 1'b0, 1'b0);
    #2;
    check_eq("fl_out_valid", DW'(out_valid), '0);
    check_eq("fl_out_ctrl", DW'(out_ctrl), '0);
    check_eq("fl_in_ready", DW'(in_ready), DW'(1'b1));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("fl_incoming_lost", DW'(out_valid), '0);

    // Stall counter saturation and clear.
    step(1'b1, a.c, a.d, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("cnt_saturated", DW'(stall_cnt), DW'(16'hFFFF));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    #2;
    check_eq("cnt_cleared", DW'(stall_cnt), '0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the scoreboard queue.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), CW'($urandom()), rnd_data(),
           1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 127) == 0));
    end
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset between edges while holding entries.
    step(1'b1, a.c, a.d, 1'b0, 1'b0, 1'b0);
    step(1'b1, b.c, b.d, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_out_valid", DW'(out_valid), '0);
    check_eq("arst_in_ready", DW'(in_ready), DW'(1'b1));
    check_eq("arst_out_ctrl", DW'(out_ctrl), '0);
    #1;
    reset = 1'b0;
    model_reset();
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 22, control-bundle width (0 not allowed).
REQ-002 The block SHALL have parameter DATA_W, default 128, datapath-bundle width (operands, immediate, PC, register specifiers).
REQ-003 The block SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  upstream stage holds a valid instruction.
REQ-007 in_ready  out  1  this stage accepts on the current edge.
REQ-008 in_ctrl  in  CTRL_W  control signals from decode.
REQ-009 in_data  in  DATA_W  datapath bundle from decode.
REQ-010 flush  in  1  kill every held and incoming instruction (branch taken, exception).
REQ-011 out_valid  out  1  downstream holds a valid instruction.
REQ-012 out_ready  in  1  downstream consumes out_* on the current edge.
REQ-013 out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0.
REQ-014 out_data  out  DATA_W  registered datapath bundle.
REQ-015 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-016 stall_cnt  out  CNT_W  saturating count of back-pressure cycles.

Function
REQ-017 The block SHALL define in_fire = in_valid & in_ready & ~flush and out_fire = out_valid & out_ready.
REQ-018 Storage SHALL be main entry M (drives out_*) plus skid entry S; FSM states are EMPTY, ONE (M full), TWO (M and S full).
REQ-019 EMPTY: on in_fire, load M and go to ONE; otherwise stay in EMPTY.
REQ-020 ONE: with in_fire and out_fire, reload M and stay in ONE; in_fire only, load S and go to TWO; out_fire only, go to EMPTY.
REQ-021 TWO: on out_fire, move S to M and go to ONE; otherwise hold M and S unchanged.
REQ-022 in_ready SHALL be a registered output, 1 exactly when state is not TWO.
REQ-023 out_valid SHALL be 1 exactly when state is ONE or TWO.
REQ-024 Latency SHALL be one cycle from in_fire to out_valid when the stage is empty.
REQ-025 Instruction order SHALL be preserved; no entry is dropped or duplicated except by flush.
REQ-026 flush SHALL have highest priority: next state is EMPTY, any same-cycle input is discarded, and out_ctrl is zero on the next cycle.
REQ-027 out_data SHALL retain its last value when out_valid=0; only out_ctrl is forced to zero (bubble).
REQ-028 stall_cnt SHALL increment by 1 each cycle out_valid & ~out_ready and saturate at all-ones.
REQ-029 cnt_clr SHALL force stall_cnt to 0 and take priority over increment in the same cycle.

Reset
REQ-030 Reset SHALL force state EMPTY, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, S=0 and stall_cnt=0 immediately, independent of clk.
REQ-031 Reset asserted mid-transfer SHALL discard all held entries, with no partial output visible after release.

Configuration
REQ-032 When macro PIPE_STAGE_SKID_EN is defined, the block SHALL implement the S entry and the TWO state per REQ-018..022.
REQ-033 Without PIPE_STAGE_SKID_EN, the block SHALL have no S entry and no TWO state, and in_ready = out_ready | ~out_valid (combinational); REQ-019, 020 (in_fire+out_fire case), 023 and 026..029 still apply, and ONE with in_fire but no out_fire is impossible.

Structure
REQ-034 Package pipe_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and the default widths PIPE_CTRL_W=22, PIPE_DATA_W=128 and PIPE_CNT_W=16.
REQ-035 The saturating counter SHALL be sub-module pipe_stall_counter (inputs clk, reset, inc, clr; output count).

Verification
REQ-036 Bench SHALL apply reset, then in_valid=1 with in_ctrl=22'h3FFFFF and out_ready=1, and check out_valid=1 and out_ctrl=22'h3FFFFF one cycle later.
REQ-037 Bench SHALL hold out_ready=0 and push A then B, check in_ready=0 after B (SKID_EN), then raise out_ready and check A then B on consecutive cycles.
REQ-038 Bench SHALL assert flush in state TWO with in_valid=1, and check out_valid=0, out_ctrl=0 and in_ready=1 on the next cycle, with the incoming entry lost.
REQ-039 Bench SHALL hold out_valid=1 and out_ready=0 for 70000 cycles (CNT_W=16) and check stall_cnt=16'hFFFF, then check 0 one cycle after cnt_clr.
REQ-040 Bench SHALL drive random valid and ready for 10000 cycles against a scoreboard FIFO and check order and contents match, in both macro builds.
REQ-041 Bench SHALL assert reset asynchronously between edges in state TWO, and check out_valid=0 and in_ready=1 before the next clk edge.
